// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair: width, seeds, checker states.
package fib_pkg;

  localparam int FIB_W     = 16;
  localparam int SEED0_VAL = 0;
  localparam int SEED1_VAL = 1;

  typedef enum logic [1:0] {
    ST_SKIP  = 2'd0,
    ST_SEED0 = 2'd1,
    ST_SEED1 = 2'd2,
    ST_CHECK = 2'd3
  } fib_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, asynchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fibonacci_checker.sv
// Receive-side monitor: checks that each accepted term equals the sum of the previous two (mod 2^W).
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int W           = FIB_W,
  parameter int SKIP        = 1,
  parameter int STRICT_SEED = 1,
  parameter int ECW         = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           locked,
  output logic [W-1:0]   exp_data,
  output logic           chk_pulse,
  output logic           err_pulse,
  output logic           err_sticky,
  output logic [ECW-1:0] err_cnt,
  output logic [15:0]    term_cnt,
  output logic           wrap_seen,
  output logic [1:0]     dbg_state
);

  // Handshake: a sample is taken on every rising edge with in_valid=1 and clr=0; no back-pressure.
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam fib_state_t INIT_ST = (SKIP == 0) ? ST_SEED0 : ST_SKIP;

  fib_state_t     state_q;
  logic [SKW-1:0] skip_q;
  logic [W-1:0]   a_q, b_q, exp_q;
  logic           locked_q, chk_q, err_q, sticky_q, wrap_q;

  logic           accept_d;
  logic [W:0]     sum_d;
  logic           chk_event_d, err_event_d, term_inc_d;

  always_comb begin
    accept_d    = in_valid && !clr;
    sum_d       = {1'b0, a_q} + {1'b0, b_q};
    chk_event_d = 1'b0;
    err_event_d = 1'b0;
    term_inc_d  = 1'b0;
    if (accept_d) begin
      case (state_q)
        ST_SEED0: err_event_d = (STRICT_SEED != 0) && (in_data != W'(SEED0_VAL));
        ST_SEED1: err_event_d = (STRICT_SEED != 0) && (in_data != W'(SEED1_VAL));
        ST_CHECK: begin
          term_inc_d  = 1'b1;
          chk_event_d = (in_data == sum_d[W-1:0]);
          err_event_d = (in_data != sum_d[W-1:0]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT_ST;
      skip_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      locked_q <= 1'b0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      chk_q <= chk_event_d;
      err_q <= err_event_d;
      if (err_event_d) sticky_q <= 1'b1;
      if (clr) begin
        state_q  <= INIT_ST;
        skip_q   <= '0;
        a_q      <= '0;
        b_q      <= '0;
        exp_q    <= '0;
        locked_q <= 1'b0;
        wrap_q   <= 1'b0;
      end else if (in_valid) begin
        case (state_q)
          ST_SKIP: begin
            skip_q <= skip_q + 1'b1;
            if (skip_q == SKIP_LAST) state_q <= ST_SEED0;
          end
          ST_SEED0: begin
            a_q     <= in_data;
            state_q <= ST_SEED1;
          end
          ST_SEED1: begin
            b_q      <= in_data;
            exp_q    <= a_q + in_data;
            locked_q <= 1'b1;
            state_q  <= ST_CHECK;
          end
          ST_CHECK: begin
            // The observed sample is taken as truth so one bad term costs one error, not a cascade.
            a_q   <= b_q;
            b_q   <= in_data;
            exp_q <= b_q + in_data;
            if (sum_d[W]) wrap_q <= 1'b1;
          end
          default: state_q <= INIT_ST;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(16)) u_term_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (clr),
    .inc_i (term_inc_d),
    .cnt_o (term_cnt)
  );

  sat_counter #(.WIDTH(ECW)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (err_event_d),
    .cnt_o (err_cnt)
  );

  assign locked     = locked_q;
  assign exp_data   = exp_q;
  assign chk_pulse  = chk_q;
  assign err_pulse  = err_q;
  assign err_sticky = sticky_q;
  assign wrap_seen  = wrap_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed-vector bench for fibonacci_checker with default parameters (W=16, SKIP=1, STRICT_SEED=1, ECW=8).
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        locked;
  logic [15:0] exp_data;
  logic        chk_pulse;
  logic        err_pulse;
  logic        err_sticky;
  logic [7:0]  err_cnt;
  logic [15:0] term_cnt;
  logic        wrap_seen;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        clr;
    logic        valid;
    logic [15:0] data;
    logic        e_chk;
    logic        e_err;
    logic        e_lock;
    logic [15:0] e_exp;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  fibonacci_checker dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .exp_data   (exp_data),
    .chk_pulse  (chk_pulse),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .term_cnt   (term_cnt),
    .wrap_seen  (wrap_seen),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".locked"},     locked,     0);
    check({tag, ".exp_data"},   exp_data,   0);
    check({tag, ".chk_pulse"},  chk_pulse,  0);
    check({tag, ".err_pulse"},  err_pulse,  0);
    check({tag, ".err_sticky"}, err_sticky, 0);
    check({tag, ".err_cnt"},    err_cnt,    0);
    check({tag, ".term_cnt"},   term_cnt,   0);
    check({tag, ".wrap_seen"},  wrap_seen,  0);
  endtask

  // drivers: inputs change 1 ns after the rising edge, outputs sampled there too
  task automatic step(input logic c, input logic v, input logic [15:0] d);
    clr      = c;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic add_vec(input logic c, input logic v, input logic [15:0] d,
                         input logic ec, input logic ee, input logic el, input logic [15:0] ex);
    vec_t r;
    r.clr = c; r.valid = v; r.data = d;
    r.e_chk = ec; r.e_err = ee; r.e_lock = el; r.e_exp = ex;
    vecs.push_back(r);
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].valid, vecs[i].data);
      check($sformatf("%s[%0d].chk_pulse", tag, i), chk_pulse, vecs[i].e_chk);
      check($sformatf("%s[%0d].err_pulse", tag, i), err_pulse, vecs[i].e_err);
      check($sformatf("%s[%0d].locked",    tag, i), locked,    vecs[i].e_lock);
      check($sformatf("%s[%0d].exp_data",  tag, i), exp_data,  vecs[i].e_exp);
    end
    vecs.delete();
  endtask

  int fib[30];

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Correct stream with 1-0-0-1 valid gaps; gap data must be ignored.
    add_vec(0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 1,  0, 0, 1, 1);
    add_vec(0, 1, 1,  1, 0, 1, 2);
    add_vec(0, 0, 99, 0, 0, 1, 2);
    add_vec(0, 0, 99, 0, 0, 1, 2);
    add_vec(0, 1, 2,  1, 0, 1, 3);
    add_vec(0, 0, 77, 0, 0, 1, 3);
    add_vec(0, 0, 77, 0, 0, 1, 3);
    add_vec(0, 1, 3,  1, 0, 1, 5);
    add_vec(0, 1, 5,  1, 0, 1, 8);
    add_vec(0, 1, 8,  1, 0, 1, 13);
    add_vec(1, 1, 13, 0, 0, 0, 0);
    apply_vecs("good");
    check("good.term_cnt_after_clr", term_cnt, 0);
    check("good.err_cnt",            err_cnt,  0);
    check("good.err_sticky",         err_sticky, 0);
    check("good.state_after_clr",    dbg_state, 0);

    // Bad term 4 resyncs the expectation onto the observed stream.
    add_vec(0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 1,  0, 0, 1, 1);
    add_vec(0, 1, 1,  1, 0, 1, 2);
    add_vec(0, 1, 2,  1, 0, 1, 3);
    add_vec(0, 1, 4,  0, 1, 1, 6);
    add_vec(0, 1, 6,  1, 0, 1, 10);
    add_vec(0, 1, 10, 1, 0, 1, 16);
    apply_vecs("resync");
    check("resync.term_cnt",   term_cnt,   5);
    check("resync.err_cnt",    err_cnt,    1);
    check("resync.err_sticky", err_sticky, 1);
    step(1, 1, 26);
    check("clr.chk_pulse",  chk_pulse,  0);
    check("clr.locked",     locked,     0);
    check("clr.term_cnt",   term_cnt,   0);
    check("clr.err_cnt",    err_cnt,    1);
    check("clr.err_sticky", err_sticky, 1);

    // Strict seeds: 5 and 7 both violate the 0/1 seeds, 12 = 5+7 still checks.
    add_vec(0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 5,  0, 1, 0, 0);
    add_vec(0, 1, 7,  0, 1, 1, 12);
    add_vec(0, 1, 12, 1, 0, 1, 19);
    apply_vecs("strict");
    check("strict.err_cnt",  err_cnt,  3);
    check("strict.term_cnt", term_cnt, 1);
    step(1, 0, 0);

    // 30 correct terms after the skipped leading 0; first carry is on F(25).
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 30; i++) fib[i] = fib[i-1] + fib[i-2];
    step(0, 1, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 1, fib[i][15:0]);
      if (i >= 2) begin
        check($sformatf("wrap.chk[F%0d]", i), chk_pulse, 1);
        check($sformatf("wrap.err[F%0d]", i), err_pulse, 0);
        check($sformatf("wrap.seen[F%0d]", i), wrap_seen, (i >= 25) ? 1 : 0);
      end
      if (i == 24) check("wrap.exp_F25", exp_data, 9489);
    end
    check("wrap.term_cnt", term_cnt, 28);
    check("wrap.err_cnt",  err_cnt,  3);

    // Asynchronous reset between clock edges clears everything at once.
    step(0, 1, 0);
    step(0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Error counter saturates at 255 on a stream that never matches.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 300; i++) step(0, 1, 16'hFFFF);
    check("sat.err_cnt",    err_cnt,    255);
    check("sat.err_sticky", err_sticky, 1);
    check("sat.term_cnt",   term_cnt,   300);
    check("sat.err_pulse",  err_pulse,  1);
    check("sat.chk_pulse",  chk_pulse,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
